// File: rtl/code_lock.sv
// code_lock: four-key combination lock with timeout,
// timed unlock window and sticky alarm.
module code_lock #(
  parameter logic [7:0]  CODE          = 8'hE4,
  parameter logic [31:0] TIMEOUT_MAX   = 32'd10,
  parameter logic [31:0] UNLOCK_CYCLES = 32'd5,
  parameter logic [3:0]  MAX_FAIL      = 4'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_f,
  output logic       unlocked,
  output logic       alarm,
  output logic [2:0] digit_cnt,
  output logic [3:0] fail_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    UNLOCK,
    ALARM
  } state_t;

  state_t      state_q, state_d;
  logic        unl_q, unl_d;
  logic        alm_q, alm_d;
  logic [2:0]  dig_q, dig_d;
  logic [3:0]  fail_q, fail_d;
  logic        miss_q, miss_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] ucnt_q, ucnt_d;

  logic        key_ev;
  logic        key_ok;
  logic [1:0]  key_idx;
  logic [1:0]  code_ent;
  logic        ent_miss;
  logic        last;
  logic [3:0]  fail_inc;

  assign key_ev   = |key_f;
  assign last     = (dig_q == 3'd3);
  assign fail_inc = fail_q + 4'd1;
  assign ent_miss = !key_ok || (key_idx != code_ent);

  // Decode a one-hot key pulse; anything else is not a valid entry
  always_comb begin
    key_idx = 2'd0;
    key_ok  = 1'b0;
    unique case (key_f)
      4'b0001: begin key_idx = 2'd0; key_ok = 1'b1; end
      4'b0010: begin key_idx = 2'd1; key_ok = 1'b1; end
      4'b0100: begin key_idx = 2'd2; key_ok = 1'b1; end
      4'b1000: begin key_idx = 2'd3; key_ok = 1'b1; end
      default: ;
    endcase
  end

  // Pick the code entry expected at the current position
  always_comb begin
    code_ent = CODE[1:0];
    unique case (dig_q[1:0])
      2'd0: code_ent = CODE[1:0];
      2'd1: code_ent = CODE[3:2];
      2'd2: code_ent = CODE[5:4];
      2'd3: code_ent = CODE[7:6];
      default: ;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    unl_d   = unl_q;
    alm_d   = alm_q;
    dig_d   = dig_q;
    fail_d  = fail_q;
    miss_d  = miss_q;
    tmo_d   = tmo_q;
    ucnt_d  = ucnt_q;
    unique case (state_q)
      IDLE: begin
        if (key_ev) begin
          state_d = ENTRY;
          dig_d   = dig_q + 3'd1;
          miss_d  = ent_miss;
          tmo_d   = 32'd0;
        end
      end
      ENTRY: begin
        if (key_ev) begin
          tmo_d = 32'd0;
          if (last) begin
            dig_d  = 3'd0;
            miss_d = 1'b0;
            if (!miss_q && !ent_miss) begin
              state_d = UNLOCK;
              unl_d   = 1'b1;
              fail_d  = 4'd0;
              ucnt_d  = 32'd0;
            end else begin
              fail_d = fail_inc;
              if (fail_inc == MAX_FAIL) begin
                state_d = ALARM;
                alm_d   = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end
          end else begin
            dig_d  = dig_q + 3'd1;
            miss_d = miss_q | ent_miss;
          end
        end else if (tmo_q == TIMEOUT_MAX - 32'd1) begin
          state_d = IDLE;
          dig_d   = 3'd0;
          miss_d  = 1'b0;
          tmo_d   = 32'd0;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      UNLOCK: begin
        if (ucnt_q == UNLOCK_CYCLES - 32'd1) begin
          state_d = IDLE;
          unl_d   = 1'b0;
          ucnt_d  = 32'd0;
        end else begin
          ucnt_d = ucnt_q + 32'd1;
        end
      end
      ALARM: begin
        state_d = ALARM;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      unl_q   <= 1'b0;
      alm_q   <= 1'b0;
      dig_q   <= 3'd0;
      fail_q  <= 4'd0;
      miss_q  <= 1'b0;
      tmo_q   <= 32'd0;
      ucnt_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      unl_q   <= unl_d;
      alm_q   <= alm_d;
      dig_q   <= dig_d;
      fail_q  <= fail_d;
      miss_q  <= miss_d;
      tmo_q   <= tmo_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign unlocked  = unl_q;
  assign alarm     = alm_q;
  assign digit_cnt = dig_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_code_lock.sv
// tb_code_lock: directed and random stimulus for code_lock
// checked against a sequence-level reference model.
module tb_code_lock;

  localparam logic [7:0] CODE = 8'hE4;
  localparam int TMAX = 10;
  localparam int UCYC = 5;
  localparam int MAXF = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_f;
  logic       unlocked;
  logic       alarm;
  logic [2:0] digit_cnt;
  logic [3:0] fail_cnt;

  int tests = 0;
  int fails = 0;

  int q[$];
  int idle_n;
  int uleft;
  int mfail;
  bit malarm;

  code_lock #(
    .CODE(CODE),
    .TIMEOUT_MAX(32'd10),
    .UNLOCK_CYCLES(32'd5),
    .MAX_FAIL(4'd3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_f(key_f),
    .unlocked(unlocked),
    .alarm(alarm),
    .digit_cnt(digit_cnt),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  function automatic int code_at(input int i);
    logic [7:0] c;
    c = CODE >> (2 * i);
    return int'(c[1:0]);
  endfunction

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] v;
    v = 4'b0001 << i;
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    idle_n = 0;
    uleft  = 0;
    mfail  = 0;
    malarm = 0;
  endtask

  task automatic model_step(input logic [3:0] k);
    int v;
    bit ok;
    if (malarm) return;
    if (uleft > 0) begin
      uleft--;
      return;
    end
    if (k != 4'b0) begin
      v = -1;
      for (int b = 0; b < 4; b++)
        if (k == onehot(b)) v = b;
      q.push_back(v);
      idle_n = 0;
      if (q.size() == 4) begin
        ok = 1;
        for (int i = 0; i < 4; i++)
          if (q[i] != code_at(i)) ok = 0;
        q.delete();
        if (ok) begin
          uleft = UCYC;
          mfail = 0;
        end else begin
          mfail++;
          if (mfail == MAXF) malarm = 1;
        end
      end
    end else if (q.size() > 0) begin
      idle_n++;
      if (idle_n == TMAX) begin
        q.delete();
        idle_n = 0;
      end
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".unlocked"}, 32'(unlocked), 32'(uleft > 0));
    chk({ph, ".alarm"}, 32'(alarm), 32'(malarm));
    chk({ph, ".digit_cnt"}, 32'(digit_cnt), 32'(q.size()));
    chk({ph, ".fail_cnt"}, 32'(fail_cnt), 32'(mfail));
  endtask

  task automatic tick(input logic [3:0] k, input string ph);
    key_f = k;
    @(posedge clk);
    model_step(k);
    #1;
    key_f = 4'b0;
    check_all(ph);
  endtask

  task automatic idle(input int n, input string ph);
    for (int i = 0; i < n; i++) tick(4'b0, ph);
  endtask

  task automatic seq(input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] c, input logic [3:0] d,
                     input int gap, input string ph);
    tick(a, ph); idle(gap, ph);
    tick(b, ph); idle(gap, ph);
    tick(c, ph); idle(gap, ph);
    tick(d, ph);
  endtask

  // Asynchronous reset taken mid-cycle; checked before any edge.
  task automatic async_reset(input string ph);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(ph);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all(ph);
  endtask

  initial begin
    int n;
    int r;
    logic [3:0] k;
    rst_n = 1'b0;
    key_f = 4'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Correct code with gaps, then measure the open window
    seq(4'b0001, 4'b0010, 4'b0100, 4'b1000, 2, "good");
    n = unlocked ? 1 : 0;
    for (int i = 0; i < 7; i++) begin
      tick(4'b0, "good_win");
      if (unlocked) n++;
    end
    chk("unlock_len", 32'(n), 32'(UCYC));

    // Three wrong attempts latch the alarm
    for (int a = 0; a < 3; a++)
      seq(4'b0001, 4'b0010, 4'b1000, 4'b1000, 1, "wrong");
    chk("alarm_set", 32'(alarm), 32'd1);
    seq(4'b0001, 4'b0010, 4'b0100, 4'b1000, 0, "alarm_hold");
    idle(3, "alarm_hold");
    async_reset("alarm_rst");

    // Timeout after two entries, then a good attempt
    tick(4'b0001, "tmo");
    tick(4'b0010, "tmo");
    idle(9, "tmo");
    chk("tmo_pre", 32'(digit_cnt), 32'd2);
    tick(4'b0, "tmo");
    chk("tmo_abort", 32'(digit_cnt), 32'd0);
    seq(4'b0001, 4'b0010, 4'b0100, 4'b1000, 0, "tmo_good");
    idle(6, "tmo_good");

    // Key arriving on the timeout edge is accepted
    tick(4'b0001, "tmo_edge");
    idle(9, "tmo_edge");
    tick(4'b0010, "tmo_edge");
    chk("tmo_edge_win", 32'(digit_cnt), 32'd2);
    idle(12, "tmo_edge");

    // Success clears the failure count
    seq(4'b0010, 4'b0010, 4'b0100, 4'b1000, 0, "clr");
    chk("clr_fail1", 32'(fail_cnt), 32'd1);
    seq(4'b0001, 4'b0010, 4'b0100, 4'b1000, 0, "clr");
    chk("clr_fail0", 32'(fail_cnt), 32'd0);
    idle(6, "clr");

    // Multi-key entry is a mismatch
    seq(4'b0011, 4'b0010, 4'b0100, 4'b1000, 0, "multi");
    chk("multi_fail", 32'(fail_cnt), 32'd1);
    idle(2, "multi");

    // Keys ignored while open; reset drops unlocked at once
    seq(4'b0001, 4'b0010, 4'b0100, 4'b1000, 0, "win");
    tick(4'b0001, "win_key");
    chk("win_dig", 32'(digit_cnt), 32'd0);
    async_reset("win_rst");

    // Reset after three entries
    tick(4'b0001, "mid");
    tick(4'b0010, "mid");
    tick(4'b0100, "mid");
    async_reset("mid_rst");
    seq(4'b0001, 4'b0010, 4'b0100, 4'b1000, 0, "fresh");
    idle(6, "fresh");

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (malarm || r == 99) begin
        async_reset("rnd_rst");
      end else if (r < 3) begin
        idle(TMAX + 2, "rnd");
      end else begin
        if (r < 50) k = 4'b0;
        else if (r < 80) k = onehot(code_at(q.size() % 4));
        else if (r < 92) k = onehot($urandom_range(0, 3));
        else k = 4'($urandom_range(1, 15));
        tick(k, "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
